// File: rtl/regs_sb_pkg.sv
// Shared widths and helpers for the integer register file
// and its write scoreboard.
package regs_sb_pkg;

  localparam int   REGS_DATA_W  = 32;
  localparam int   REGS_ADDR_W  = 5;
  localparam int   REGS_NUM_RD  = 2;
  localparam int   SB_CNT_W_DEF = 2;
  localparam logic ZERO         = 1'b0;

  // Two single-bit retire strobes summed into a 0..2 count.
  function automatic logic [1:0] dec_sum(input logic a,
                                         input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/regs_sb_cnt.sv
// One scoreboard slice: in-flight count for a single register,
// with clamp-to-zero and an underflow strobe.
module regs_sb_cnt
  import regs_sb_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             inc_i,
  input  logic [1:0]       dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             uflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   dec_w;

  always_comb begin
    sum     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc_i};
    dec_w   = (CNT_W+1)'(dec_i);
    uflow_o = (sum < dec_w);
    cnt_d   = uflow_o ? '0 : CNT_W'(sum - dec_w);
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/regs_sb.sv
// Register file with combinational read bypass and a per-register
// pending-write scoreboard feeding decode's stall logic.
module regs_sb
  import regs_sb_pkg::*;
#(
  parameter int DATA_W   = REGS_DATA_W,
  parameter int ADDR_W   = REGS_ADDR_W,
  parameter int NUM_RD   = REGS_NUM_RD,
  parameter int SB_CNT_W = SB_CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rest,
  input  logic [NUM_RD*ADDR_W-1:0] id2regs_rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] regs2id_rd_data_o,
  output logic [NUM_RD-1:0]        regs2id_rd_busy_o,
  input  logic                     id2regs_iss_en_i,
  input  logic [ADDR_W-1:0]        id2regs_iss_rd_i,
  output logic                     regs2id_iss_rdy_o,
  input  logic                     wb0_en_i,
  input  logic [ADDR_W-1:0]        wb0_addr_i,
  input  logic [DATA_W-1:0]        wb0_data_i,
  input  logic                     wb0_clr_i,
  input  logic                     wb1_en_i,
  input  logic [ADDR_W-1:0]        wb1_addr_i,
  input  logic [DATA_W-1:0]        wb1_data_i,
  input  logic                     wb1_clr_i,
  output logic                     regs2ctl_sb_err_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [SB_CNT_W-1:0] cnt    [DEPTH];
  logic [1:0]          dec    [DEPTH];
  logic [DEPTH-1:0]    inc;
  logic [DEPTH-1:0]    uflow;
  logic [ADDR_W-1:0]   rd_a   [NUM_RD];
  logic                err_q, err_d;
  logic                iss_rdy;

  assign iss_rdy = (id2regs_iss_rd_i == '0) |
                   (cnt[id2regs_iss_rd_i] != CNT_MAX);

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      dec[r] = dec_sum(
        wb0_en_i & wb0_clr_i & (wb0_addr_i == ADDR_W'(r)),
        wb1_en_i & wb1_clr_i & (wb1_addr_i == ADDR_W'(r)));
      inc[r] = id2regs_iss_en_i & iss_rdy & (r != 0) &
               (id2regs_iss_rd_i == ADDR_W'(r));
    end
  end

  assign cnt[0]   = '0;
  assign uflow[0] = ZERO;

  for (genvar g = 1; g < DEPTH; g++) begin : g_sb
    regs_sb_cnt #(.CNT_W(SB_CNT_W)) u_cnt (
      .clk     (clk),
      .rest    (rest),
      .inc_i   (inc[g]),
      .dec_i   (dec[g]),
      .cnt_o   (cnt[g]),
      .uflow_o (uflow[g])
    );
  end

  always_comb begin
    err_d = err_q | (|uflow) |
            (id2regs_iss_en_i & ~iss_rdy);
  end

  // WB1 is applied first so a same-address WB0 overrides it.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      if (wb1_en_i && wb1_addr_i == ADDR_W'(r))
        regs_d[r] = wb1_data_i;
      if (wb0_en_i && wb0_addr_i == ADDR_W'(r))
        regs_d[r] = wb0_data_i;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      for (int r = 0; r < DEPTH; r++)
        regs_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++)
        regs_q[r] <= regs_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    regs2id_rd_data_o = '0;
    regs2id_rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_a[k] = id2regs_rd_addr_i[k*ADDR_W +: ADDR_W];
      regs2id_rd_data_o[k*DATA_W +: DATA_W] = regs_q[rd_a[k]];
      if (wb1_en_i && wb1_addr_i == rd_a[k])
        regs2id_rd_data_o[k*DATA_W +: DATA_W] = wb1_data_i;
      if (wb0_en_i && wb0_addr_i == rd_a[k])
        regs2id_rd_data_o[k*DATA_W +: DATA_W] = wb0_data_i;
      if (rd_a[k] == '0 || !rest)
        regs2id_rd_data_o[k*DATA_W +: DATA_W] = '0;
      // A register retiring this cycle already reads not-busy.
      regs2id_rd_busy_o[k] = (rd_a[k] != '0) &&
        ({1'b0, cnt[rd_a[k]]} > (SB_CNT_W+1)'(dec[rd_a[k]]));
    end
  end

  assign regs2id_iss_rdy_o = iss_rdy;
  assign regs2ctl_sb_err_o = err_q;

endmodule

// File: tb/tb_regs_sb.sv
// Self-checking bench for regs_sb: directed scenarios plus a
// randomized run against a behavioural register/scoreboard model.
module tb_regs_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 3;
  localparam int CW   = 2;
  localparam int NREG = 32;
  localparam int MAXC = 3;

  logic             clk = 1'b0;
  logic             rest = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             iss_en = 1'b0;
  logic [AW-1:0]    iss_rd = '0;
  logic             iss_rdy;
  logic             wb0_en = 1'b0, wb1_en = 1'b0;
  logic [AW-1:0]    wb0_addr = '0, wb1_addr = '0;
  logic [DW-1:0]    wb0_data = '0, wb1_data = '0;
  logic             wb0_clr = 1'b0, wb1_clr = 1'b0;
  logic             sb_err;

  int nchk = 0;
  int nfail = 0;

  logic [DW-1:0] m_regs [NREG];
  int            m_cnt  [NREG];
  bit            m_err;

  regs_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .SB_CNT_W(CW)) dut (
    .clk               (clk),
    .rest              (rest),
    .id2regs_rd_addr_i (rd_addr),
    .regs2id_rd_data_o (rd_data),
    .regs2id_rd_busy_o (rd_busy),
    .id2regs_iss_en_i  (iss_en),
    .id2regs_iss_rd_i  (iss_rd),
    .regs2id_iss_rdy_o (iss_rdy),
    .wb0_en_i          (wb0_en),
    .wb0_addr_i        (wb0_addr),
    .wb0_data_i        (wb0_data),
    .wb0_clr_i         (wb0_clr),
    .wb1_en_i          (wb1_en),
    .wb1_addr_i        (wb1_addr),
    .wb1_data_i        (wb1_data),
    .wb1_clr_i         (wb1_clr),
    .regs2ctl_sb_err_o (sb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rdp(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic int m_dec(input int r);
    int d = 0;
    if (r == 0) return 0;
    if (wb0_en && wb0_clr && int'(wb0_addr) == r) d++;
    if (wb1_en && wb1_clr && int'(wb1_addr) == r) d++;
    return d;
  endfunction

  function automatic bit m_rdy();
    return (iss_rd == 0) || (m_cnt[iss_rd] != MAXC);
  endfunction

  function automatic logic [DW-1:0] m_rd(input int a);
    if (a == 0) return '0;
    if (wb0_en && int'(wb0_addr) == a) return wb0_data;
    if (wb1_en && int'(wb1_addr) == a) return wb1_data;
    return m_regs[a];
  endfunction

  function automatic bit m_busy(input int a);
    if (a == 0) return 1'b0;
    return (m_cnt[a] - m_dec(a)) > 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_commit();
    bit rdy;
    int v;
    int nc [NREG];
    rdy = m_rdy();
    if (iss_en && !rdy) m_err = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      v = m_cnt[r] - m_dec(r);
      if (r != 0 && iss_en && rdy && int'(iss_rd) == r) v++;
      if (v < 0) begin
        v = 0;
        m_err = 1'b1;
      end
      nc[r] = v;
    end
    for (int r = 0; r < NREG; r++) m_cnt[r] = nc[r];
    if (wb1_en && wb1_addr != 0) m_regs[wb1_addr] = wb1_data;
    if (wb0_en && wb0_addr != 0) m_regs[wb0_addr] = wb0_data;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 0; iss_rd = '0;
    wb0_en = 0; wb0_addr = '0; wb0_data = '0; wb0_clr = 0;
    wb1_en = 0; wb1_addr = '0; wb1_data = '0; wb1_clr = 0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic apply_reset();
    idle();
    rest = 0;
    model_clear();
    @(posedge clk);
    #1;
    rest = 1;
  endtask

  task automatic test_reset();
    idle();
    wb0_en = 1; wb0_addr = 5; wb0_data = 32'hDEAD;
    iss_en = 1; iss_rd = 5;
    wb1_en = 1; wb1_clr = 1; wb1_addr = 6; wb1_data = 32'h6;
    tick();
    idle();
    set_rd(0, 5);
    #2;
    nchk++;
    if (rdp(0) !== 32'hDEAD || rd_busy[0] !== 1'b1 || sb_err !== 1'b1) begin
      nfail++;
      $display("FAIL reset_pre: data=%h busy=%b err=%b want DEAD 1 1",
               rdp(0), rd_busy[0], sb_err);
    end
    #1;
    wb0_en = 1; wb0_addr = 5; wb0_data = 32'h1234;
    rest = 0;
    model_clear();
    #1;
    nchk++;
    if (rdp(0) !== '0 || rd_busy[0] !== 1'b0 || sb_err !== 1'b0 ||
        iss_rdy !== 1'b1) begin
      nfail++;
      $display("FAIL reset_async: data=%h busy=%b err=%b rdy=%b want 0 0 0 1",
               rdp(0), rd_busy[0], sb_err, iss_rdy);
    end
    idle();
    @(posedge clk);
    #3;
    rest = 1;
    @(posedge clk);
    #1;
    #2;
    nchk++;
    if (rdp(0) !== '0 || rd_busy[0] !== 1'b0) begin
      nfail++;
      $display("FAIL reset_after: data=%h busy=%b want 0 0",
               rdp(0), rd_busy[0]);
    end
  endtask

  task automatic test_x0();
    idle();
    wb0_en = 1; wb0_addr = 0; wb0_data = 32'hFFFF_FFFF;
    set_rd(0, 0);
    #2;
    nchk++;
    if (rdp(0) !== '0) begin
      nfail++;
      $display("FAIL x0_same: got %h want 0", rdp(0));
    end
    tick();
    idle();
    #2;
    nchk++;
    if (rdp(0) !== '0) begin
      nfail++;
      $display("FAIL x0_next: got %h want 0", rdp(0));
    end
    for (int i = 0; i < 4; i++) begin
      iss_en = 1; iss_rd = 0;
      #2;
      nchk++;
      if (iss_rdy !== 1'b1 || rd_busy[0] !== 1'b0) begin
        nfail++;
        $display("FAIL x0_issue%0d: rdy=%b busy=%b want 1 0",
                 i, iss_rdy, rd_busy[0]);
      end
      tick();
    end
    idle();
    #2;
    nchk++;
    if (sb_err !== 1'b0 || rd_busy[0] !== 1'b0) begin
      nfail++;
      $display("FAIL x0_err: err=%b busy=%b want 0 0", sb_err, rd_busy[0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    wb0_en = 1; wb0_addr = 3; wb0_data = 32'h11;
    wb1_en = 1; wb1_addr = 3; wb1_data = 32'h22;
    set_rd(0, 3);
    #2;
    nchk++;
    if (rdp(0) !== 32'h11) begin
      nfail++;
      $display("FAIL byp_both: got %h want 11", rdp(0));
    end
    tick();
    idle();
    #2;
    nchk++;
    if (rdp(0) !== 32'h11) begin
      nfail++;
      $display("FAIL byp_stored: got %h want 11", rdp(0));
    end
    wb1_en = 1; wb1_addr = 4; wb1_data = 32'h33;
    wb0_en = 0; wb0_addr = 4; wb0_data = 32'h55;
    set_rd(1, 4);
    #2;
    nchk++;
    if (rdp(1) !== 32'h33) begin
      nfail++;
      $display("FAIL byp_wb1: got %h want 33", rdp(1));
    end
    tick();
    idle();
    #2;
    nchk++;
    if (rdp(1) !== 32'h33) begin
      nfail++;
      $display("FAIL byp_wb1_stored: got %h want 33", rdp(1));
    end
  endtask

  task automatic test_saturation();
    idle();
    set_rd(0, 7);
    for (int i = 0; i < 3; i++) begin
      iss_en = 1; iss_rd = 7;
      tick();
    end
    idle();
    iss_rd = 7;
    #2;
    nchk++;
    if (rd_busy[0] !== 1'b1 || iss_rdy !== 1'b0 || sb_err !== 1'b0) begin
      nfail++;
      $display("FAIL sat_full: busy=%b rdy=%b err=%b want 1 0 0",
               rd_busy[0], iss_rdy, sb_err);
    end
    iss_en = 1;
    tick();
    idle();
    iss_rd = 7;
    #2;
    nchk++;
    if (sb_err !== 1'b1 || rd_busy[0] !== 1'b1 || iss_rdy !== 1'b0) begin
      nfail++;
      $display("FAIL sat_over: err=%b busy=%b rdy=%b want 1 1 0",
               sb_err, rd_busy[0], iss_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      wb0_en = 1; wb0_clr = 1; wb0_addr = 7; wb0_data = DW'(i);
      #2;
      nchk++;
      if (rd_busy[0] !== (i != 2)) begin
        nfail++;
        $display("FAIL sat_clr%0d: busy=%b want %b", i, rd_busy[0], i != 2);
      end
      tick();
    end
    idle();
    iss_rd = 7;
    #2;
    nchk++;
    if (rd_busy[0] !== 1'b0 || iss_rdy !== 1'b1) begin
      nfail++;
      $display("FAIL sat_drained: busy=%b rdy=%b want 0 1",
               rd_busy[0], iss_rdy);
    end
    apply_reset();
  endtask

  task automatic test_simultaneous();
    idle();
    set_rd(0, 9);
    iss_en = 1; iss_rd = 9;
    tick();
    iss_en = 1; iss_rd = 9;
    wb0_en = 1; wb0_clr = 1; wb0_addr = 9; wb0_data = 32'h99;
    #2;
    nchk++;
    if (rd_busy[0] !== 1'b0) begin
      nfail++;
      $display("FAIL sim_same_cycle: busy=%b want 0", rd_busy[0]);
    end
    tick();
    idle();
    #2;
    nchk++;
    if (rd_busy[0] !== 1'b1 || sb_err !== 1'b0) begin
      nfail++;
      $display("FAIL sim_cancel: busy=%b err=%b want 1 0", rd_busy[0], sb_err);
    end
    wb0_en = 1; wb0_clr = 1; wb0_addr = 9; wb0_data = 32'h90;
    wb1_en = 1; wb1_clr = 1; wb1_addr = 9; wb1_data = 32'h91;
    #2;
    nchk++;
    if (rdp(0) !== 32'h90) begin
      nfail++;
      $display("FAIL sim_dual_data: got %h want 90", rdp(0));
    end
    tick();
    idle();
    #2;
    nchk++;
    if (rd_busy[0] !== 1'b0 || sb_err !== 1'b1 || rdp(0) !== 32'h90) begin
      nfail++;
      $display("FAIL sim_underflow: busy=%b err=%b data=%h want 0 1 90",
               rd_busy[0], sb_err, rdp(0));
    end
    apply_reset();
  endtask

  task automatic test_multiport();
    idle();
    wb0_en = 1; wb0_addr = 1; wb0_data = 32'hA;
    wb1_en = 1; wb1_addr = 2; wb1_data = 32'hB;
    tick();
    idle();
    wb1_en = 1; wb1_addr = 2; wb1_data = 32'hC;
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 1);
    #2;
    nchk++;
    if (rdp(0) !== 32'hA || rdp(1) !== 32'hC || rdp(2) !== 32'hA) begin
      nfail++;
      $display("FAIL multi: got %h %h %h want A C A", rdp(0), rdp(1), rdp(2));
    end
    tick();
    idle();
    #2;
    nchk++;
    if (rdp(1) !== 32'hC) begin
      nfail++;
      $display("FAIL multi_stored: got %h want C", rdp(1));
    end
  endtask

  task automatic test_random();
    int ra;
    idle();
    for (int n = 0; n < 400; n++) begin
      iss_rd = AW'($urandom_range(0, 7));
      iss_en = m_rdy() ? ($urandom_range(0, 2) == 0)
                       : ($urandom_range(0, 15) == 0);
      wb0_en   = $urandom_range(0, 1);
      wb0_addr = AW'($urandom_range(0, 7));
      wb0_data = $urandom;
      wb0_clr  = (m_cnt[wb0_addr] > 0) ? $urandom_range(0, 1)
                                       : ($urandom_range(0, 15) == 0);
      wb1_en   = $urandom_range(0, 1);
      wb1_addr = AW'($urandom_range(0, 7));
      wb1_data = $urandom;
      wb1_clr  = (m_cnt[wb1_addr] > 0) ? $urandom_range(0, 1)
                                       : ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(0, 7));
      #2;
      for (int k = 0; k < NR; k++) begin
        ra = int'(rd_addr[k*AW +: AW]);
        nchk++;
        if (rdp(k) !== m_rd(ra) || rd_busy[k] !== m_busy(ra)) begin
          nfail++;
          $display("FAIL rnd%0d_p%0d x%0d: data=%h busy=%b want %h %b",
                   n, k, ra, rdp(k), rd_busy[k], m_rd(ra), m_busy(ra));
        end
      end
      nchk++;
      if (iss_rdy !== m_rdy() || sb_err !== m_err) begin
        nfail++;
        $display("FAIL rnd%0d_ctl: rdy=%b err=%b want %b %b",
                 n, iss_rdy, sb_err, m_rdy(), m_err);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    model_clear();
    idle();
    rest = 0;
    repeat (2) @(posedge clk);
    #1;
    rest = 1;
    test_reset();
    test_x0();
    test_bypass();
    test_saturation();
    test_simultaneous();
    test_multiport();
    apply_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
